wavelet_pe_source: RTL and testbench
====================================

Name: wavelet_pe_source

Overview:
Read-side counterpart of the wavelet PE output sink. It streams one decomposition level's input samples from a synchronous-read sample buffer into the HP/LP FIR pair. The FIR pair sees a ready/valid sample stream. After the last real sample, the block appends tail samples to flush the filters, then signals completion to the PE controller. Buffer addressing is base plus offset, modulo the buffer size, so a region may wrap past the top of the buffer.

Parameters:
INPUT_WIDTH, 32, sample width in bits
BUFF_CELL_COUNT, 2048, buffer depth (power of two)
FLUSH_LEN, 3, number of tail samples appended after the real samples (FIR taps minus 1)
BUFF_ADDR_WIDTH, $clog2(BUFF_CELL_COUNT), buffer address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a pass; ignored while busy=1
src_base_addr  in  BUFF_ADDR_WIDTH  first sample address; sampled on an accepted start
src_len  in  BUFF_ADDR_WIDTH  number of real samples; sampled on an accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle pulse at the end of a pass
rd_en  out  1  buffer read strobe
rd_addr  out  BUFF_ADDR_WIDTH  buffer read address
rd_data  in  INPUT_WIDTH  read data; valid the cycle after rd_en
fir_input  out  INPUT_WIDTH  sample to the FIR pair
fir_input_valid  out  1  fir_input holds a sample
fir_input_ready  in  1  FIR pair accepts the sample this cycle
sample_count  out  BUFF_ADDR_WIDTH  samples accepted in this pass, including tail samples

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, fir_input=0, fir_input_valid=0, sample_count=0. The FSM returns to IDLE and the internal buffer is emptied.
- Reset asserted mid-pass aborts the pass. No done pulse is generated.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE:
  - start with src_len≠0 → READ. Base and length are latched, and the read offset and sample_count are cleared.
  - start with src_len=0 → DONE. No samples are issued, including no tail samples.
- READ:
  - rd_addr = (base + rd_offset) mod BUFF_CELL_COUNT, using natural BUFF_ADDR_WIDTH-bit wrap.
  - rd_en is asserted only while rd_offset < len and buffer credits exist. rd_offset increments on each rd_en.
  - Each rd_data word is captured into a 2-entry output buffer (output register plus skid register) in the cycle after its rd_en.
  - Credit rule: entries + reads in flight ≤ 2 at all times. A pop in the current cycle frees a credit in the same cycle.
  - Leave for FLUSH when all len samples have been accepted by the FIR.
- FLUSH:
  - Presents FLUSH_LEN tail samples, each with value 0.
  - → DONE after the last tail sample is accepted.
- DONE: done=1 for one cycle, busy drops in the same cycle, → IDLE.
- Handshake:
  - A sample transfers when fir_input_valid and fir_input_ready are both high.
  - While fir_input_valid=1 and fir_input_ready=0, fir_input is held stable.
  - No sample is dropped or duplicated.
- Latency: start sampled at edge 0 → rd_en in cycle 1 → first fir_input_valid in cycle 3.
- Throughput: with fir_input_ready held high, one sample is transferred per cycle with no bubbles after the first.
- sample_count increments on every transfer, both real and tail samples, and holds its final value until the next accepted start.
- rd_en is never asserted outside READ.
- start during busy is ignored and has no side effects.

Optional Feature:
WAVELET_SRC_MIRROR_EN
- Defined: tail samples are a whole-point symmetric extension of the input instead of zeros.
  - Tail sample k (k=0..FLUSH_LEN-1) is x[len-2-k], read from the buffer through the same credit and addressing path.
  - The mirror index saturates at offset 0 when len-2-k < 0.
  - With len=1, every tail sample is x[0].
  - FLUSH then issues reads like READ does.
- Undefined: tail samples are zeros and no reads are issued in FLUSH.

Test Plan:
1. Buffer mem[a]=3a, base=10, len=4, FLUSH_LEN=3, ready=1 → fir_input 30,33,36,39,0,0,0 on consecutive cycles, first in cycle 3. done pulses once after the last transfer, and sample_count=7.
2. base=2046, len=4, BUFF_CELL_COUNT=2048 → rd_addr sequence 2046,2047,0,1, and data is delivered in that order.
3. len=8, fir_input_ready toggling 1,0,1,0… and also held low for 5 cycles → every sample delivered exactly once in order, fir_input stable while stalled, never more than 2 reads outstanding plus buffered.
4. start with len=0 → done pulses in the following cycle, with no rd_en and no fir_input_valid. A second start asserted while busy on a len=6 pass → ignored, and exactly 6+FLUSH_LEN samples are transferred.
5. Reset asserted in the third cycle of READ → all outputs at reset values immediately, no done pulse. A new start then runs a normal pass.
6. With WAVELET_SRC_MIRROR_EN defined, data 1,2,3,4,5, len=5, FLUSH_LEN=3 → stream 1,2,3,4,5,4,3,2. With len=1 and data 7 → stream 7,7,7,7.

Source files
------------

// File: rtl/wavelet_pe_source.sv
// -----------------------------------------------------------------------------
// wavelet_pe_source
//
// Streams one decomposition level's input samples from a synchronous-read
// sample buffer into the HP/LP FIR pair over a ready/valid interface. Once
// the last real sample has been accepted, FLUSH_LEN tail samples are
// appended to flush the filter delay lines, then done pulses for one cycle.
// Buffer addresses are base + offset, wrapping naturally at the top of the
// buffer.
//
// Build option (macro): WAVELET_SRC_MIRROR_EN
//   undefined : tail samples are zeros; no buffer reads are issued for them
//   defined   : tail sample k is x[len-2-k] (whole-point symmetric extension,
//               saturating at x[0]), fetched through the normal read path
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             single-cycle pulse, begins a pass when not busy
//   src_base_addr     first sample address (latched on an accepted start)
//   src_len           number of real samples (latched on an accepted start)
//   busy              pass in progress (READ or FLUSH)
//   done              single-cycle end-of-pass pulse
//   rd_en, rd_addr    buffer read strobe and address
//   rd_data           buffer read data, valid the cycle after rd_en
//   fir_input         sample presented to the FIR pair
//   fir_input_valid   fir_input holds a sample
//   fir_input_ready   FIR pair accepts the sample this cycle
//   sample_count      samples transferred this pass (real + tail)
// -----------------------------------------------------------------------------
module wavelet_pe_source #(
    parameter int INPUT_WIDTH     = 32,
    parameter int BUFF_CELL_COUNT = 2048,
    parameter int FLUSH_LEN       = 3,
    parameter int BUFF_ADDR_WIDTH = $clog2(BUFF_CELL_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BUFF_ADDR_WIDTH-1:0] src_base_addr,
    input  logic [BUFF_ADDR_WIDTH-1:0] src_len,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [BUFF_ADDR_WIDTH-1:0] rd_addr,
    input  logic [INPUT_WIDTH-1:0]     rd_data,
    output logic [INPUT_WIDTH-1:0]     fir_input,
    output logic                       fir_input_valid,
    input  logic                       fir_input_ready,
    output logic [BUFF_ADDR_WIDTH-1:0] sample_count
);

    // Two spare bits so len + FLUSH_LEN and 2*len never overflow.
    localparam int IDX_W = BUFF_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [BUFF_ADDR_WIDTH-1:0] base_reg;
    logic [BUFF_ADDR_WIDTH-1:0] len_reg;
    logic [IDX_W-1:0]           issue_idx_reg;   // reads issued this pass
    logic [IDX_W-1:0]           xfer_cnt_reg;    // samples transferred this pass
    logic                       pending_reg;     // read in flight: rd_data valid now
    logic [1:0]                 count_reg;       // output buffer occupancy
    logic [INPUT_WIDTH-1:0]     out_reg;         // head entry, drives fir_input
    logic [INPUT_WIDTH-1:0]     skid_reg;        // second entry

    logic                       start_accept;
    logic [IDX_W-1:0]           len_ext;
    logic [IDX_W-1:0]           flush_len_ext;
    logic [IDX_W-1:0]           read_total;
    logic [BUFF_ADDR_WIDTH-1:0] rd_offset;
    logic                       read_phase;
    logic                       flush_zero;
    logic                       buf_valid;
    logic                       buf_pop;
    logic                       xfer;
    logic                       last_real;
    logic                       last_tail;
    logic [2:0]                 occupancy;
    logic                       credit_ok;

    // -------------------------------------------------------------------------
    // Common combinational terms
    // -------------------------------------------------------------------------
    assign start_accept  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign len_ext       = {2'b00, len_reg};
    assign flush_len_ext = IDX_W'(FLUSH_LEN);

    assign buf_valid = (count_reg != 2'd0);
    assign buf_pop   = buf_valid && fir_input_ready;
    assign xfer      = fir_input_valid && fir_input_ready;

    assign last_real = (xfer_cnt_reg == (len_ext - IDX_W'(1)));
    assign last_tail = (xfer_cnt_reg == (len_ext + flush_len_ext - IDX_W'(1)));

`ifdef WAVELET_SRC_MIRROR_EN
    // Tail samples come from the buffer, so the read sequence simply runs
    // FLUSH_LEN entries past the real data. Tail reads may be prefetched
    // while still in READ; that keeps the stream bubble-free across the
    // real/tail boundary.
    logic [IDX_W-1:0] two_len_m2;

    assign two_len_m2 = {len_ext[IDX_W-2:0], 1'b0} - IDX_W'(2);
    assign read_phase = (state_reg == READ) || (state_reg == FLUSH);
    assign read_total = len_ext + flush_len_ext;
    assign flush_zero = 1'b0;

    // Read index i >= len maps to x[2*len-2-i], clamped at x[0]. The
    // difference is < len whenever it is used, so address-width math is exact.
    always_comb begin
        rd_offset = issue_idx_reg[BUFF_ADDR_WIDTH-1:0];
        if (issue_idx_reg >= len_ext) begin
            if (issue_idx_reg > two_len_m2) begin
                rd_offset = '0;
            end else begin
                rd_offset = two_len_m2[BUFF_ADDR_WIDTH-1:0]
                          - issue_idx_reg[BUFF_ADDR_WIDTH-1:0];
            end
        end
    end
`else
    // Tail samples are constant zeros presented directly in FLUSH, which
    // needs no buffer traffic and follows the last real sample without a gap.
    assign read_phase = (state_reg == READ);
    assign read_total = len_ext;
    assign flush_zero = (state_reg == FLUSH);
    assign rd_offset  = issue_idx_reg[BUFF_ADDR_WIDTH-1:0];
`endif

    // Credit check: entries + reads in flight may never exceed 2. A pop in
    // this cycle frees its slot immediately, which is what allows one read
    // per cycle while the FIR keeps accepting.
    assign occupancy = {1'b0, count_reg} + {2'b00, pending_reg};
    assign credit_ok = occupancy < (3'd2 + {2'b00, buf_pop});

    assign rd_en   = read_phase && (issue_idx_reg < read_total) && credit_ok;
    assign rd_addr = base_reg + rd_offset;   // natural wrap at buffer top

    assign fir_input_valid = buf_valid || flush_zero;
    assign fir_input       = buf_valid ? out_reg : '0;
    assign sample_count    = xfer_cnt_reg[BUFF_ADDR_WIDTH-1:0];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start_accept) begin
                    // A zero-length pass goes straight to DONE with no tail.
                    state_next = (src_len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (xfer && last_real) begin
                    state_next = (FLUSH_LEN == 0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && last_tail) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            READ, FLUSH: busy = 1'b1;
            DONE:        done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pass bookkeeping: latched parameters, read index, transfer counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg      <= '0;
            len_reg       <= '0;
            issue_idx_reg <= '0;
            xfer_cnt_reg  <= '0;
            pending_reg   <= 1'b0;
        end else begin
            pending_reg <= rd_en;
            if (start_accept) begin
                base_reg      <= src_base_addr;
                len_reg       <= src_len;
                issue_idx_reg <= '0;
                xfer_cnt_reg  <= '0;
            end else begin
                if (rd_en) begin
                    issue_idx_reg <= issue_idx_reg + IDX_W'(1);
                end
                if (xfer) begin
                    xfer_cnt_reg <= xfer_cnt_reg + IDX_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Two-entry output buffer. rd_data is pushed the cycle after its rd_en;
    // out_reg only changes on a pop or when filling an empty buffer, so the
    // presented sample is stable while the FIR stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 2'd0;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else begin
            case (count_reg)
                2'd0: begin
                    if (pending_reg) begin
                        out_reg   <= rd_data;
                        count_reg <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pending_reg && buf_pop) begin
                        out_reg <= rd_data;
                    end else if (pending_reg) begin
                        skid_reg  <= rd_data;
                        count_reg <= 2'd2;
                    end else if (buf_pop) begin
                        count_reg <= 2'd0;
                    end
                end
                2'd2: begin
                    // Credits guarantee no read is in flight when full.
                    if (buf_pop) begin
                        out_reg   <= skid_reg;
                        count_reg <= 2'd1;
                    end
                end
                default: count_reg <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_wavelet_pe_source.sv
module tb_wavelet_pe_source;

    localparam int IW  = 32;
    localparam int CC  = 2048;
    localparam int FL  = 3;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_base_addr;
    logic [AW-1:0] src_len;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data = '0;
    logic [IW-1:0] fir_input;
    logic          fir_input_valid;
    logic          fir_input_ready;
    logic [AW-1:0] sample_count;

    int checks = 0;
    int passes = 0;

    wavelet_pe_source #(
        .INPUT_WIDTH(IW),
        .BUFF_CELL_COUNT(CC),
        .FLUSH_LEN(FL),
        .BUFF_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .src_base_addr(src_base_addr),
        .src_len(src_len),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .fir_input(fir_input),
        .fir_input_valid(fir_input_valid),
        .fir_input_ready(fir_input_ready),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample buffer model
    logic [IW-1:0] mem [0:CC-1];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction log, sampled on the falling edge
    logic [IW-1:0] xfer_q[$];
    int            xfer_cyc_q[$];
    logic [AW-1:0] rdaddr_q[$];
    int            done_cyc_q[$];
    int            valid_cycles, reads_total, xfers_total, max_out, stall_viol;
    logic          prev_stall;
    logic [IW-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (fir_input_valid !== 1'b1 || fir_input !== prev_data))
                stall_viol++;
            if (fir_input_valid) valid_cycles++;
            if (rd_en) begin
                reads_total++;
                rdaddr_q.push_back(rd_addr);
            end
            if (fir_input_valid && fir_input_ready) begin
                xfers_total++;
                xfer_q.push_back(fir_input);
                xfer_cyc_q.push_back(cyc);
                $display("xfer cyc=%0d data=%0d count_before=%0d", cyc, fir_input, sample_count);
            end
            if (reads_total - xfers_total > max_out) max_out = reads_total - xfers_total;
            if (done) done_cyc_q.push_back(cyc);
            prev_stall = fir_input_valid && !fir_input_ready;
            prev_data  = fir_input;
        end
    end

    task automatic clear_log();
        xfer_q.delete();
        xfer_cyc_q.delete();
        rdaddr_q.delete();
        done_cyc_q.delete();
        valid_cycles = 0;
        reads_total  = 0;
        xfers_total  = 0;
        max_out      = 0;
        stall_viol   = 0;
    endtask

    task automatic start_pass(input logic [AW-1:0] b, input logic [AW-1:0] l, output int c0);
        src_base_addr = b;
        src_len       = l;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int n = 0;
        while (done_cyc_q.size() == 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cyc_q.size() == 0)
            $display("FAIL %s_timeout: no done within %0d cycles", name, max_cycles);
        else
            passes++;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else passes++;
        if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else passes++;
        if (fir_input !== '0) $display("FAIL reset_fir_input: got %0d want 0", fir_input); else passes++;
        if (fir_input_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fir_input_valid); else passes++;
        if (sample_count !== '0) $display("FAIL reset_sample_count: got %0d want 0", sample_count); else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || fir_input_valid !== 1'b0)
            $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0", busy, fir_input_valid);
        else passes++;
    endtask

    task automatic test_basic();
        logic [IW-1:0] exp [7];
        int c0;
`ifdef WAVELET_SRC_MIRROR_EN
        exp = '{30, 33, 36, 39, 36, 33, 30};
`else
        exp = '{30, 33, 36, 39, 0, 0, 0};
`endif
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd10, 11'd4, c0);
        checks += 3;
        if (rd_en !== 1'b1) $display("FAIL basic_rd_en_cycle1: got %b want 1", rd_en); else passes++;
        if (rd_addr !== 11'd10) $display("FAIL basic_rd_addr0: got %0d want 10", rd_addr); else passes++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
        wait_done(50, "basic");
        checks++;
        if (xfer_q.size() != 7) $display("FAIL basic_count: got %0d want 7", xfer_q.size()); else passes++;
        for (int i = 0; i < 7; i++) begin
            if (i < xfer_q.size()) begin
                checks += 2;
                if (xfer_q[i] !== exp[i])
                    $display("FAIL basic_data[%0d]: got %0d want %0d", i, xfer_q[i], exp[i]);
                else passes++;
                if (xfer_cyc_q[i] != c0 + 2 + i)
                    $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, xfer_cyc_q[i], c0 + 2 + i);
                else passes++;
            end
        end
        checks += 3;
        if (done_cyc_q.size() != 1) $display("FAIL basic_done_count: got %0d want 1", done_cyc_q.size());
        else passes++;
        if (done_cyc_q.size() > 0 && done_cyc_q[0] != c0 + 9)
            $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc_q[0], c0 + 9);
        else passes++;
        if (sample_count !== 11'd7) $display("FAIL basic_sample_count: got %0d want 7", sample_count);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        logic [IW-1:0] exp_d [4];
        int c0;
        exp_a = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        exp_d = '{32'd6138, 32'd6141, 32'd0, 32'd3};
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd2046, 11'd4, c0);
        wait_done(50, "wrap");
        checks++;
        if (rdaddr_q.size() < 4 || xfer_q.size() < 4)
            $display("FAIL wrap_sizes: reads=%0d xfers=%0d want >=4", rdaddr_q.size(), xfer_q.size());
        else begin
            passes++;
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (rdaddr_q[i] !== exp_a[i])
                    $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, rdaddr_q[i], exp_a[i]);
                else passes++;
                if (xfer_q[i] !== exp_d[i])
                    $display("FAIL wrap_data[%0d]: got %0d want %0d", i, xfer_q[i], exp_d[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_stall();
        logic [IW-1:0] exp [11];
        int c0;
        int n = 0;
`ifdef WAVELET_SRC_MIRROR_EN
        exp = '{300, 303, 306, 309, 312, 315, 318, 321, 318, 315, 312};
`else
        exp = '{300, 303, 306, 309, 312, 315, 318, 321, 0, 0, 0};
`endif
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd100, 11'd8, c0);
        while (done_cyc_q.size() == 0 && n < 300) begin
            fir_input_ready = (n >= 6 && n < 11) ? 1'b0 : ((n % 2) == 0);
            @(posedge clk);
            #1;
            n++;
        end
        fir_input_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks += 4;
        if (done_cyc_q.size() != 1) $display("FAIL stall_done: got %0d pulses want 1", done_cyc_q.size());
        else passes++;
        if (xfer_q.size() != 11) $display("FAIL stall_count: got %0d want 11", xfer_q.size()); else passes++;
        if (stall_viol != 0) $display("FAIL stall_stable: got %0d violations want 0", stall_viol); else passes++;
        if (max_out > 2) $display("FAIL stall_outstanding: got %0d want <=2", max_out); else passes++;
        for (int i = 0; i < 11; i++) begin
            if (i < xfer_q.size()) begin
                checks++;
                if (xfer_q[i] !== exp[i])
                    $display("FAIL stall_data[%0d]: got %0d want %0d", i, xfer_q[i], exp[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_zero_len();
        int c0;
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd5, 11'd0, c0);
        checks += 2;
        if (done !== 1'b1) $display("FAIL zero_done_next: got %b want 1", done); else passes++;
        if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else passes++;
        repeat (5) @(posedge clk);
        #1;
        checks += 3;
        if (reads_total != 0) $display("FAIL zero_reads: got %0d want 0", reads_total); else passes++;
        if (valid_cycles != 0) $display("FAIL zero_valid: got %0d want 0", valid_cycles); else passes++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0)
            $display("FAIL zero_done_once: got %0d pulses want 1 at cycle %0d", done_cyc_q.size(), c0);
        else passes++;
    endtask

    task automatic test_back_to_back_start();
        logic [IW-1:0] exp [9];
        int c0;
`ifdef WAVELET_SRC_MIRROR_EN
        exp = '{600, 603, 606, 609, 612, 615, 612, 609, 606};
`else
        exp = '{600, 603, 606, 609, 612, 615, 0, 0, 0};
`endif
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd200, 11'd6, c0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_start_busy: got %b want 1", busy); else passes++;
        src_base_addr = 11'd0;
        src_len       = 11'd2;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, "busy_start");
        checks += 3;
        if (xfer_q.size() != 9) $display("FAIL busy_start_count: got %0d want 9", xfer_q.size()); else passes++;
        if (sample_count !== 11'd9) $display("FAIL busy_start_sample_count: got %0d want 9", sample_count);
        else passes++;
        if (done_cyc_q.size() != 1) $display("FAIL busy_start_done: got %0d want 1", done_cyc_q.size());
        else passes++;
        for (int i = 0; i < 9; i++) begin
            if (i < xfer_q.size()) begin
                checks++;
                if (xfer_q[i] !== exp[i])
                    $display("FAIL busy_start_data[%0d]: got %0d want %0d", i, xfer_q[i], exp[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [IW-1:0] exp [4];
        int c0;
        exp = '{30, 33, 36, 39};
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd10, 11'd8, c0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fir_input_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", fir_input_valid);
        else passes++;
        #1 rst = 1'b1;
        #1;
        checks += 6;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
        if (rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b want 0", rd_en); else passes++;
        if (rd_addr !== '0) $display("FAIL midrst_rd_addr: got %0d want 0", rd_addr); else passes++;
        if (fir_input_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", fir_input_valid); else passes++;
        if (fir_input !== '0) $display("FAIL midrst_fir_input: got %0d want 0", fir_input); else passes++;
        if (sample_count !== '0) $display("FAIL midrst_sample_count: got %0d want 0", sample_count); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cyc_q.size() != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_cyc_q.size());
        else passes++;
        start_pass(11'd10, 11'd4, c0);
        wait_done(50, "midrst_rerun");
        checks += 2;
        if (xfer_q.size() != 4 + FL) $display("FAIL midrst_rerun_count: got %0d want %0d", xfer_q.size(), 4 + FL);
        else passes++;
        if (xfer_cyc_q.size() > 0 && xfer_cyc_q[0] != c0 + 2)
            $display("FAIL midrst_rerun_latency: got %0d want %0d", xfer_cyc_q[0], c0 + 2);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            if (i < xfer_q.size()) begin
                checks++;
                if (xfer_q[i] !== exp[i])
                    $display("FAIL midrst_rerun_data[%0d]: got %0d want %0d", i, xfer_q[i], exp[i]);
                else passes++;
            end
        end
    endtask

`ifdef WAVELET_SRC_MIRROR_EN
    task automatic test_mirror();
        logic [IW-1:0] exp5 [8];
        int c0;
        exp5 = '{1, 2, 3, 4, 5, 4, 3, 2};
        for (int i = 0; i < 5; i++) mem[1000 + i] = 32'(i + 1);
        mem[1500] = 32'd7;
        clear_log();
        fir_input_ready = 1'b1;
        start_pass(11'd1000, 11'd5, c0);
        wait_done(60, "mirror5");
        checks++;
        if (xfer_q.size() != 8) $display("FAIL mirror5_count: got %0d want 8", xfer_q.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            if (i < xfer_q.size()) begin
                checks++;
                if (xfer_q[i] !== exp5[i])
                    $display("FAIL mirror5_data[%0d]: got %0d want %0d", i, xfer_q[i], exp5[i]);
                else passes++;
            end
        end
        clear_log();
        start_pass(11'd1500, 11'd1, c0);
        wait_done(60, "mirror1");
        checks++;
        if (xfer_q.size() != 4) $display("FAIL mirror1_count: got %0d want 4", xfer_q.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            if (i < xfer_q.size()) begin
                checks++;
                if (xfer_q[i] !== 32'd7)
                    $display("FAIL mirror1_data[%0d]: got %0d want 7", i, xfer_q[i]);
                else passes++;
            end
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < CC; a++) mem[a] = 32'(3 * a);
        start           = 1'b0;
        src_base_addr   = '0;
        src_len         = '0;
        fir_input_ready = 1'b1;
        prev_stall      = 1'b0;
        prev_data       = '0;
        clear_log();

        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_back_to_back_start();
        test_mid_reset();
`ifdef WAVELET_SRC_MIRROR_EN
        test_mirror();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
